pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
Central stall/flush sequencer for the 5-stage ARM pipeline. Combines the ID-stage hazard_detected flag, the EXE-stage branch_taken flag and the MEM-stage SRAM handshake into per-register freeze/flush controls. Tracks multi-cycle SRAM waits with a watchdog and keeps saturating performance counters. Sits at top level beside the hazard unit; it drives the PC register, IF/ID, ID/EXE, EXE/MEM and MEM/WB enables.

Parameters:
MAX_WAIT, 64, maximum consecutive SRAM wait cycles before a timeout error is raised (≥2).
CNT_W, 16, width of each performance counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
hazard_detected  input  1  RAW hazard from the hazard unit (ID stage).
branch_taken  input  1  branch resolved as taken in EXE.
mem_req  input  1  MEM stage issues an SRAM read or write this cycle.
sram_ready  input  1  SRAM controller signals completion of the current access.
perf_clr  input  1  synchronous clear of all three counters.
freeze_pc  output  1  hold PC register.
freeze_if_id  output  1  hold IF/ID register.
flush_if_id  output  1  load NOP into IF/ID.
flush_id_exe  output  1  load NOP (bubble) into ID/EXE.
freeze_back  output  1  hold ID/EXE, EXE/MEM and MEM/WB registers.
mem_timeout  output  1  sticky watchdog error.
stall_cnt  output  CNT_W  hazard-stall cycles.
flush_cnt  output  CNT_W  branch flush events.
wait_cnt  output  CNT_W  SRAM freeze cycles.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high.
- States: RUN, MEM_WAIT, ERROR. Reset → RUN, internal wait timer = 0, mem_timeout = 0, all counters = 0.
- While rst = 1, all combinational outputs (freeze_*, flush_*) are forced to 0.
- mem_freeze (combinational):
  - RUN: mem_req & ~sram_ready.
  - MEM_WAIT: ~sram_ready.
  - ERROR: 1.
- Transitions:
  - RUN → MEM_WAIT when mem_req & ~sram_ready; timer ← 1.
  - MEM_WAIT → RUN when sram_ready.
  - MEM_WAIT, not ready: timer increments.
  - MEM_WAIT → ERROR when timer == MAX_WAIT and ~sram_ready.
  - ERROR is terminal until rst.
- mem_timeout is registered and equals 1 exactly when the state is ERROR.
- Priority when mem_freeze = 1:
  - Outputs: freeze_pc = freeze_if_id = freeze_back = 1; flush_if_id = flush_id_exe = 0.
  - hazard_detected and branch_taken are ignored, because EXE is held and the branch re-presents after release.
- Priority when mem_freeze = 0 and branch_taken = 1:
  - Outputs: flush_if_id = flush_id_exe = 1; all freezes = 0.
  - Branch overrides hazard, so the stalled instruction is squashed.
- Priority when mem_freeze = 0, branch_taken = 0 and hazard_detected = 1:
  - Outputs: freeze_pc = freeze_if_id = 1, flush_id_exe = 1, freeze_back = 0.
- Otherwise all controls are 0.
- All control outputs are combinational with zero latency, so they take effect at the same clock edge.
- Counters update on the clock edge after the qualifying cycle:
  - stall_cnt +1 per hazard-stall cycle.
  - flush_cnt +1 per branch-flush cycle.
  - wait_cnt +1 per mem_freeze cycle, including ERROR cycles.
- All counters saturate at 2^CNT_W−1 with no wrap.
- perf_clr takes precedence over increment in the same cycle and does not affect the FSM or mem_timeout.
- sram_ready in the same cycle as mem_req in RUN causes no freeze and no state change.
- sram_ready while in RUN without mem_req is ignored.
- Reset asserted mid-wait returns to RUN next edge with the timer cleared.

Test Plan:
- Reset, then idle 5 cycles → all controls 0, counters 0, state RUN, mem_timeout 0.
- hazard_detected = 1 for 2 cycles → freeze_pc = freeze_if_id = flush_id_exe = 1 both cycles; stall_cnt = 2.
- hazard_detected = 1 and branch_taken = 1 together → flush_if_id = flush_id_exe = 1, freeze_pc = 0; flush_cnt = 1, stall_cnt unchanged.
- mem_req = 1, sram_ready low 3 cycles then high, with branch_taken = 1 throughout:
  - Freeze outputs = 1 and flush outputs = 0 for 3 cycles.
  - Ready cycle gives flush_if_id = 1.
  - wait_cnt = 3; state returns to RUN.
- MAX_WAIT = 4, mem_req = 1, sram_ready held 0 → ERROR and mem_timeout = 1 after the 4th wait cycle, with freeze held; rst pulse → RUN, mem_timeout = 0.
- CNT_W = 2, 5 hazard cycles → stall_cnt saturates at 3; perf_clr while hazard is high → stall_cnt = 0 next edge.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline: merges ID hazards, EXE
// branches and the MEM-stage SRAM handshake into per-register freeze/flush controls.
module pipeline_stall_controller #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  input  logic             perf_clr,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             freeze_back,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt,
  output logic [1:0]       state_dbg
);

  // Handshake: the MEM stage holds mem_req until sram_ready is seen high; a cycle
  // with mem_req & sram_ready completes the access with no freeze at all.

  localparam int TMR_W = $clog2(MAX_WAIT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(MAX_WAIT);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERROR    = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic             mem_freeze;
  logic             hazard_stall;
  logic             branch_flush;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      timer       <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      mem_timeout <= (state_nxt == S_ERROR);
    end
  end

  // Next-state logic; timer counts wait cycles, starting at 1 on entry.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      S_RUN: begin
        if (mem_req && !sram_ready) begin
          state_nxt = S_MEM_WAIT;
          timer_nxt = TMR_ONE;
        end
      end
      S_MEM_WAIT: begin
        if (sram_ready) begin
          state_nxt = S_RUN;
          timer_nxt = '0;
        end else if (timer == TMR_MAX) begin
          state_nxt = S_ERROR;
        end else begin
          timer_nxt = timer + TMR_ONE;
        end
      end
      S_ERROR: begin
        state_nxt = S_ERROR;
      end
      default: begin
        state_nxt = S_RUN;
        timer_nxt = '0;
      end
    endcase
  end

  // Output logic: memory freeze beats branch flush beats hazard stall.
  always_comb begin
    mem_freeze   = 1'b0;
    hazard_stall = 1'b0;
    branch_flush = 1'b0;
    freeze_pc    = 1'b0;
    freeze_if_id = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_exe = 1'b0;
    freeze_back  = 1'b0;
    if (!rst) begin
      case (state)
        S_RUN:      mem_freeze = mem_req && !sram_ready;
        S_MEM_WAIT: mem_freeze = !sram_ready;
        S_ERROR:    mem_freeze = 1'b1;
        default:    mem_freeze = 1'b0;
      endcase
      if (mem_freeze) begin
        freeze_pc    = 1'b1;
        freeze_if_id = 1'b1;
        freeze_back  = 1'b1;
      end else if (branch_taken) begin
        branch_flush = 1'b1;
        flush_if_id  = 1'b1;
        flush_id_exe = 1'b1;
      end else if (hazard_detected) begin
        hazard_stall = 1'b1;
        freeze_pc    = 1'b1;
        freeze_if_id = 1'b1;
        flush_id_exe = 1'b1;
      end
    end
  end

  assign state_dbg = state;

  // Saturating performance counters; perf_clr wins over an increment.
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      stall_cnt <= '0;
    end else if (hazard_stall && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      flush_cnt <= '0;
    end else if (branch_flush && (flush_cnt != CNT_MAX)) begin
      flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      wait_cnt <= '0;
    end else if (mem_freeze && (wait_cnt != CNT_MAX)) begin
      wait_cnt <= wait_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: a wide-counter instance and a
// 2-bit-counter instance share stimulus; expected values are hand-derived.
module tb_pipeline_stall_controller;

  localparam int MAX_WAIT = 4;
  localparam int CNT_A    = 8;
  localparam int CNT_B    = 2;

  // {freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, freeze_back}
  localparam logic [4:0] C_IDLE   = 5'b00000;
  localparam logic [4:0] C_STALL  = 5'b11010;
  localparam logic [4:0] C_FLUSH  = 5'b00110;
  localparam logic [4:0] C_FREEZE = 5'b11001;

  logic clk = 1'b0;
  logic rst, hazard_detected, branch_taken, mem_req, sram_ready, perf_clr;

  logic a_freeze_pc, a_freeze_if_id, a_flush_if_id, a_flush_id_exe, a_freeze_back;
  logic a_mem_timeout;
  logic [CNT_A-1:0] a_stall_cnt, a_flush_cnt, a_wait_cnt;
  logic [1:0] a_state;

  logic b_freeze_pc, b_freeze_if_id, b_flush_if_id, b_flush_id_exe, b_freeze_back;
  logic b_mem_timeout;
  logic [CNT_B-1:0] b_stall_cnt, b_flush_cnt, b_wait_cnt;
  logic [1:0] b_state;

  logic [4:0] a_ctrl;
  assign a_ctrl = {a_freeze_pc, a_freeze_if_id, a_flush_if_id, a_flush_id_exe, a_freeze_back};

  int n_checks = 0;
  int n_errors = 0;

  // Clock/reset block
  always #5 clk = ~clk;

  pipeline_stall_controller #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_A)) u_dut_a (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_req(mem_req), .sram_ready(sram_ready), .perf_clr(perf_clr),
    .freeze_pc(a_freeze_pc), .freeze_if_id(a_freeze_if_id), .flush_if_id(a_flush_if_id),
    .flush_id_exe(a_flush_id_exe), .freeze_back(a_freeze_back), .mem_timeout(a_mem_timeout),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt), .wait_cnt(a_wait_cnt),
    .state_dbg(a_state)
  );

  pipeline_stall_controller #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_B)) u_dut_b (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_req(mem_req), .sram_ready(sram_ready), .perf_clr(perf_clr),
    .freeze_pc(b_freeze_pc), .freeze_if_id(b_freeze_if_id), .flush_if_id(b_flush_if_id),
    .flush_id_exe(b_flush_id_exe), .freeze_back(b_freeze_back), .mem_timeout(b_mem_timeout),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt), .wait_cnt(b_wait_cnt),
    .state_dbg(b_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1ns after the edge, outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic hz, input logic br, input logic mr, input logic rdy);
    hazard_detected = hz;
    branch_taken    = br;
    mem_req         = mr;
    sram_ready      = rdy;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    perf_clr = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("rst_forces_ctrl_0", 32'(a_ctrl), 32'(C_IDLE));
    step();
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_state", 32'(a_state), 0);
    check("rst_timeout", 32'(a_mem_timeout), 0);
    check("rst_stall_cnt", 32'(a_stall_cnt), 0);
    check("rst_flush_cnt", 32'(a_flush_cnt), 0);
    check("rst_wait_cnt", 32'(a_wait_cnt), 0);

    for (int i = 0; i < 5; i++) begin
      check($sformatf("idle_ctrl_%0d", i), 32'(a_ctrl), 32'(C_IDLE));
      step();
    end
    check("idle_stall_cnt", 32'(a_stall_cnt), 0);
    check("idle_state", 32'(a_state), 0);

    // Two hazard cycles
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("hazard_ctrl_%0d", i), 32'(a_ctrl), 32'(C_STALL));
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("hazard_stall_cnt", 32'(a_stall_cnt), 2);
    check("hazard_stall_cnt_b", 32'(b_stall_cnt), 2);

    // Branch overrides hazard
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("branch_over_hazard", 32'(a_ctrl), 32'(C_FLUSH));
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("branch_flush_cnt", 32'(a_flush_cnt), 1);
    check("branch_stall_cnt", 32'(a_stall_cnt), 2);

    // Three SRAM wait cycles with branch held, then ready
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("memwait_ctrl_%0d", i), 32'(a_ctrl), 32'(C_FREEZE));
      step();
      check($sformatf("memwait_state_%0d", i), 32'(a_state), 1);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    check("memwait_release_flush", 32'(a_ctrl), 32'(C_FLUSH));
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("memwait_back_to_run", 32'(a_state), 0);
    check("memwait_wait_cnt", 32'(a_wait_cnt), 3);
    check("memwait_flush_cnt", 32'(a_flush_cnt), 2);

    // Ready in the request cycle, and ready without a request
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    check("req_ready_same_cycle", 32'(a_ctrl), 32'(C_IDLE));
    step();
    check("req_ready_state", 32'(a_state), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("ready_no_req", 32'(a_ctrl), 32'(C_IDLE));
    step();
    check("ready_no_req_state", 32'(a_state), 0);
    check("ready_no_req_wait_cnt", 32'(a_wait_cnt), 3);

    // Watchdog: 1 RUN cycle + 4 MEM_WAIT cycles, then ERROR
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("wd_ctrl_%0d", i), 32'(a_ctrl), 32'(C_FREEZE));
      check($sformatf("wd_timeout_pre_%0d", i), 32'(a_mem_timeout), 0);
      step();
      check($sformatf("wd_state_%0d", i), 32'(a_state), (i == 5) ? 2 : 1);
      check($sformatf("wd_timeout_%0d", i), 32'(a_mem_timeout), (i == 5) ? 1 : 0);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    check("error_holds_freeze", 32'(a_ctrl), 32'(C_FREEZE));
    step();
    check("error_terminal", 32'(a_state), 2);
    check("error_wait_cnt", 32'(a_wait_cnt), 9);
    check("error_wait_cnt_sat_b", 32'(b_wait_cnt), 3);
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    check("perf_clr_in_error", 32'(a_wait_cnt), 0);
    check("perf_clr_keeps_state", 32'(a_state), 2);
    check("perf_clr_keeps_timeout", 32'(a_mem_timeout), 1);
    rst = 1'b1;
    #1;
    check("rst_masks_error_ctrl", 32'(a_ctrl), 32'(C_IDLE));
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("post_error_state", 32'(a_state), 0);
    check("post_error_timeout", 32'(a_mem_timeout), 0);
    check("post_error_ctrl", 32'(a_ctrl), 32'(C_IDLE));

    // Reset in the middle of a wait, then a fresh wait must run the full 5 cycles
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("midwait_rst_state", 32'(a_state), 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step();
    check("midwait_timer_cleared", 32'(a_state), 1);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    step();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;

    // Counter saturation on the 2-bit instance, then perf_clr under a hazard
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    check("sat_stall_cnt_b", 32'(b_stall_cnt), 3);
    check("sat_stall_cnt_a", 32'(a_stall_cnt), 5);
    perf_clr = 1'b1;
    #1;
    check("perf_clr_ctrl", 32'(a_ctrl), 32'(C_STALL));
    step();
    perf_clr = 1'b0;
    check("perf_clr_stall_b", 32'(b_stall_cnt), 0);
    check("perf_clr_stall_a", 32'(a_stall_cnt), 0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("after_clr_stall_a", 32'(a_stall_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
